core_run_ctrl: RTL
==================

Name: core_run_ctrl

Overview:
- Sequencing controller for the single-cycle RV32I datapath.
- Decodes the fetched instruction into datapath control signals (register/memory enables, ALU operation, PC and write-back selects).
- Gates all state-changing enables through a run/step/halt FSM, so software or a bench can start, single-step, pause and trap the core.
- Keeps retired-instruction and taken-branch counters. Sits between the top level and the datapath.

Parameters:
- CNT_W, 32, width of retired_cnt and taken_cnt; counters wrap modulo 2^CNT_W.
- TRAP_ON_ILLEGAL, 1, 1 = unknown opcode enters TRAP; 0 = treated as NOP and retired.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- run_req  in  1  pulse: IDLE/HALT -> RUN
- step_req  in  1  pulse: IDLE/HALT -> execute exactly one instruction
- halt_req  in  1  level/pulse: RUN -> HALT at next instruction boundary
- instruction_out  in  32  fetched instruction from datapath
- alu_zero_flag  in  1  ALU zero flag
- last_instr_flag_out  in  1  instruction memory end marker
- reg_write_en, mem_read_en, mem_write_en, alu_src_b, branch_en, zero_test_signal, pc_write_en, jal_active, jalr_active  out  1 each  datapath controls
- mem_to_reg_sel  out  2  00 ALU, 01 mem, 10 PC+4
- pc_sel  out  2  00 PC+4, 01 branch, 10 ALU target
- alu_op_ctrl  out  4  0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR, 3 idle
- state_o  out  3  current FSM state encoding
- retired_cnt  out  CNT_W  instructions committed
- taken_cnt  out  CNT_W  branches/jumps that redirected PC
- trap_o  out  1  high while in TRAP

Behaviour:
- Reset (clk edge with rst=1): state IDLE, counters 0, trap_o 0, all enables 0, pc_sel 00, mem_to_reg_sel 00, alu_op_ctrl 3. Reset mid-operation aborts the current instruction; no commit occurs that cycle.
- States:
  - IDLE=0: waits for run_req or step_req.
  - RUN=1: commits one instruction per cycle.
  - STEP=2: commits once, then goes to HALT.
  - HALT=3: resumes on run_req or step_req.
  - DONE=4: terminal until rst.
  - TRAP=5: terminal until rst.
- Commit cycle: state RUN or STEP, last_instr_flag_out=0, and the opcode is legal (or TRAP_ON_ILLEGAL=0).
  - Only in a commit cycle are reg_write_en, mem_write_en, mem_read_en and pc_write_en driven from the decode; otherwise they are 0, pc_sel=00 and alu_op_ctrl=3.
  - Decode is combinational; latency is 0 cycles from instruction_out to controls.
- Decode (opcode):
  - R 0110011: ADD/SUB/AND/OR/SLT by funct3/funct7.
  - I-ALU 0010011: alu_src_b=1.
  - LW 0000011: ADD, alu_src_b=1, mem_read_en=1, mem_to_reg_sel=01.
  - SW 0100011: ADD, alu_src_b=1, mem_write_en=1, reg_write_en=0.
  - BEQ/BNE 1100011: SUB, branch_en=1, pc_sel=01, zero_test_signal = (funct3==001).
  - JAL 1101111: jal_active=1, ADD, pc_sel=10, mem_to_reg_sel=10.
  - JALR 1100111: jalr_active=1, same selects as JAL.
  - jal_active and jalr_active are never both 1.
- Counters (committed instructions only):
  - retired_cnt +1 per commit.
  - taken_cnt +1 on JAL/JALR, or on a branch where (alu_zero_flag XOR zero_test_signal)=1.
  - Both wrap to 0 at 2^CNT_W.
- Transitions:
  - IDLE/HALT: run_req beats step_req if both are high in the same cycle.
  - RUN: halt_req=1 commits the current instruction, then goes to HALT.
  - DONE takes priority over halt: last_instr_flag_out=1 in RUN/STEP goes to DONE without commit.
  - Illegal opcode in RUN/STEP with TRAP_ON_ILLEGAL=1 goes to TRAP without commit; trap_o=1 the following cycle.
  - Requests in DONE/TRAP are ignored.
  - step_req while in RUN is ignored.

Decomposition:
- Package core_ctrl_pkg:
  - enum run_state_t.
  - opcode constants OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR.
  - ALU code constants ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_IDLE=3, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12.
  - struct ctrl_bundle_t holding all decoded controls.
- Sub-module: core_decode, purely combinational (instruction -> ctrl_bundle_t plus illegal flag); core_run_ctrl gates its outputs.

Test Plan:
- Reset, then idle 5 cycles -> state_o=0, all enables 0, alu_op_ctrl=3, retired_cnt=0.
- step_req with instruction 0x002081B3 (add x3,x1,x2) -> one cycle with reg_write_en=1, alu_op_ctrl=2, mem_to_reg_sel=00; then state_o=3, retired_cnt=1.
- run_req with 0x00000463 (beq x0,x0,8), alu_zero_flag=1 -> pc_sel=01, branch_en=1, alu_op_ctrl=6, taken_cnt=1; with 0x010000EF (jal x1,16) -> jal_active=1, pc_sel=10, mem_to_reg_sel=10, taken_cnt=2.
- RUN with 0x00002283 (lw) then 0x00502223 (sw) -> mem_read_en=1/mem_to_reg_sel=01, then mem_write_en=1/reg_write_en=0; halt_req on sw cycle -> sw commits, state_o=3, retired_cnt +2.
- RUN with 0x0000007F -> no enables that cycle, trap_o=1, state_o=5, counters frozen; subsequent run_req ignored; rst returns state to IDLE.
- RUN with last_instr_flag_out=1 -> state_o=4, no commit; run_req and step_req do nothing.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the RV32I run/step controller and its decoder.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_HALT = 3'd3,
    ST_DONE = 3'd4,
    ST_TRAP = 3'd5
  } run_state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_IDLE = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_NOR  = 4'd12;

  typedef struct packed {
    logic       reg_write_en;
    logic       mem_read_en;
    logic       mem_write_en;
    logic       alu_src_b;
    logic       branch_en;
    logic       zero_test_signal;
    logic       pc_write_en;
    logic       jal_active;
    logic       jalr_active;
    logic [1:0] mem_to_reg_sel;
    logic [1:0] pc_sel;
    logic [3:0] alu_op_ctrl;
  } ctrl_bundle_t;

  // SUB only exists for register-register ops; immediate forms with funct7[5] set stay ADD.
  function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3,
                                                input logic funct7_b5,
                                                input logic is_reg);
    case (funct3)
      3'b000:  return (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Datapath-facing control bus: instruction/flags in, decoded controls out.
interface core_run_ctrl_if;
  logic [31:0] instruction_out;
  logic        alu_zero_flag;
  logic        last_instr_flag_out;
  logic        reg_write_en;
  logic        mem_read_en;
  logic        mem_write_en;
  logic        alu_src_b;
  logic        branch_en;
  logic        zero_test_signal;
  logic        pc_write_en;
  logic        jal_active;
  logic        jalr_active;
  logic [1:0]  mem_to_reg_sel;
  logic [1:0]  pc_sel;
  logic [3:0]  alu_op_ctrl;

  modport master (
    input  instruction_out, alu_zero_flag, last_instr_flag_out,
    output reg_write_en, mem_read_en, mem_write_en, alu_src_b, branch_en,
           zero_test_signal, pc_write_en, jal_active, jalr_active,
           mem_to_reg_sel, pc_sel, alu_op_ctrl
  );

  modport slave (
    output instruction_out, alu_zero_flag, last_instr_flag_out,
    input  reg_write_en, mem_read_en, mem_write_en, alu_src_b, branch_en,
           zero_test_signal, pc_write_en, jal_active, jalr_active,
           mem_to_reg_sel, pc_sel, alu_op_ctrl
  );
endinterface

// File: rtl/core_decode.sv
// Combinational RV32I opcode decoder: instruction -> control bundle plus illegal flag.
module core_decode
  import core_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];

  always_comb begin
    ctrl             = '0;
    ctrl.alu_op_ctrl = ALU_IDLE;
    ctrl.pc_write_en = 1'b1;
    illegal          = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write_en = 1'b1;
        ctrl.alu_op_ctrl  = alu_from_funct(funct3, funct7_b5, 1'b1);
      end
      OP_I: begin
        ctrl.reg_write_en = 1'b1;
        ctrl.alu_src_b    = 1'b1;
        ctrl.alu_op_ctrl  = alu_from_funct(funct3, funct7_b5, 1'b0);
      end
      OP_LW: begin
        ctrl.reg_write_en   = 1'b1;
        ctrl.mem_read_en    = 1'b1;
        ctrl.alu_src_b      = 1'b1;
        ctrl.mem_to_reg_sel = 2'b01;
        ctrl.alu_op_ctrl    = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write_en = 1'b1;
        ctrl.alu_src_b    = 1'b1;
        ctrl.alu_op_ctrl  = ALU_ADD;
      end
      OP_BR: begin
        ctrl.branch_en        = 1'b1;
        ctrl.pc_sel           = 2'b01;
        ctrl.zero_test_signal = (funct3 == 3'b001);
        ctrl.alu_op_ctrl      = ALU_SUB;
      end
      OP_JAL: begin
        ctrl.reg_write_en   = 1'b1;
        ctrl.jal_active     = 1'b1;
        ctrl.pc_sel         = 2'b10;
        ctrl.mem_to_reg_sel = 2'b10;
        ctrl.alu_op_ctrl    = ALU_ADD;
      end
      OP_JALR: begin
        ctrl.reg_write_en   = 1'b1;
        ctrl.jalr_active    = 1'b1;
        ctrl.alu_src_b      = 1'b1;
        ctrl.pc_sel         = 2'b10;
        ctrl.mem_to_reg_sel = 2'b10;
        ctrl.alu_op_ctrl    = ALU_ADD;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run/step/halt sequencer: gates decoded controls to commit cycles and counts retirements.
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W           = 32,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               halt_req,
  core_run_ctrl_if.master    dp,
  output logic [2:0]         state_o,
  output logic [CNT_W-1:0]   retired_cnt,
  output logic [CNT_W-1:0]   taken_cnt,
  output logic               trap_o
);

  run_state_t   state;
  ctrl_bundle_t dec;
  ctrl_bundle_t ctrl;
  logic         illegal;
  logic         trap_now;
  logic         commit;
  logic         taken;

  core_decode u_decode (
    .instr   (dp.instruction_out),
    .ctrl    (dec),
    .illegal (illegal)
  );

  assign trap_now = illegal && TRAP_ON_ILLEGAL;
  assign commit   = ((state == ST_RUN) || (state == ST_STEP)) &&
                    !dp.last_instr_flag_out && !trap_now;
  assign taken    = dec.jal_active || dec.jalr_active ||
                    (dec.branch_en && (dp.alu_zero_flag ^ dec.zero_test_signal));

  always_comb begin
    ctrl             = '0;
    ctrl.alu_op_ctrl = ALU_IDLE;
    if (commit) ctrl = dec;
  end

  assign dp.reg_write_en     = ctrl.reg_write_en;
  assign dp.mem_read_en      = ctrl.mem_read_en;
  assign dp.mem_write_en     = ctrl.mem_write_en;
  assign dp.alu_src_b        = ctrl.alu_src_b;
  assign dp.branch_en        = ctrl.branch_en;
  assign dp.zero_test_signal = ctrl.zero_test_signal;
  assign dp.pc_write_en      = ctrl.pc_write_en;
  assign dp.jal_active       = ctrl.jal_active;
  assign dp.jalr_active      = ctrl.jalr_active;
  assign dp.mem_to_reg_sel   = ctrl.mem_to_reg_sel;
  assign dp.pc_sel           = ctrl.pc_sel;
  assign dp.alu_op_ctrl      = ctrl.alu_op_ctrl;

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      retired_cnt <= '0;
      taken_cnt   <= '0;
      trap_o      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (run_req)       state <= ST_RUN;
          else if (step_req) state <= ST_STEP;
        end
        ST_RUN, ST_STEP: begin
          // End-of-program outranks both trap and halt; neither commits.
          if (dp.last_instr_flag_out) begin
            state <= ST_DONE;
          end else if (trap_now) begin
            state  <= ST_TRAP;
            trap_o <= 1'b1;
          end else if (state == ST_STEP || halt_req) begin
            state <= ST_HALT;
          end
        end
        default: state <= state;
      endcase
      if (commit) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
        if (taken) taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule
